uart_transmitter: RTL and testbench

//  Buffered 8N1 serial transmitter: the TX counterpart of the PROM-loading UART receiver.

---
 rtl/uart_transmitter.sv | 182 ++++++++++++++++++
 tb/tb_uart_transmitter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//   Buffered 8N1 serial transmitter. CPU stores to the TX data word are queued
//   in a small circular FIFO and serialized LSB first on tx_o: one start bit,
//   eight data bits and one stop bit, each DIVISOR clocks long.
//   Queued frames are sent back to back with no idle gap between them.
//
// Parameters
//   CLOCK_HZ  system clock frequency in Hz
//   BAUD      serial bit rate; DIVISOR = CLOCK_HZ / BAUD (must be >= 1)
//   DEPTH     FIFO depth in bytes (power of 2, >= 2)
//
// Ports
//   clk         system clock, all logic on posedge
//   reset       synchronous active-high; flushes the FIFO and aborts any frame
//   tx_data_i   byte to enqueue (sampled only on an accepting edge)
//   tx_valid_i  enqueue request
//   tx_ready_o  FIFO not full
//   tx_o        registered serial line, idle high
//   busy_o      frame in progress or FIFO non-empty
//   level_o     bytes queued in the FIFO (excludes the byte in the shifter)
// -----------------------------------------------------------------------------
module uart_transmitter #(
  parameter int CLOCK_HZ = 6250,
  parameter int BAUD     = 781,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               tx_data_i,
  input  logic                     tx_valid_i,
  output logic                     tx_ready_o,
  output logic                     tx_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int DIVISOR = CLOCK_HZ / BAUD;
  localparam int CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  if (DIVISOR < 1) begin : g_bad_divisor
    $error("uart_transmitter: CLOCK_HZ / BAUD must be at least 1");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_transmitter: DEPTH must be a power of 2 and at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [7:0]         mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q;

  logic               push;
  logic               pop;
  logic               level_nz;
  logic               cnt_last;

  // Ready looks only at the registered level, so a pop in the same cycle
  // never lets a push into a full FIFO.
  assign tx_ready_o = (level_q != LVL_FULL);
  assign push       = tx_valid_i && tx_ready_o;
  assign level_nz   = (level_q != '0);
  assign cnt_last   = (cnt_q == CNT_LAST);

  // State / control register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Data storage: FIFO entries and shifter carry no reset; the control
  // state above decides whether their contents are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= tx_data_i;
    shift_q <= shift_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (level_nz) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          state_d = START;
        end
      end
      START: begin
        if (cnt_last) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_last) begin
          cnt_d = '0;
          // Chain straight into the next start bit when more bytes wait.
          if (level_nz) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: the line level is computed for the upcoming state and
  // registered, so tx_o changes exactly on the edge that enters a bit cell.
  always_comb begin
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_o = (state_q != IDLE) || level_nz;
  end

  assign tx_o    = tx_q;
  assign level_o = level_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
//   Directed bench for uart_transmitter at default parameters (DIVISOR = 8,
//   DEPTH = 4). A table of bytes with hand-written expected 10-bit frames
//   (bit 0 = start, bits 1..8 = data LSB first, bit 9 = stop) is sent one
//   at a time, followed by hand-written sequences for back-to-back frames,
//   FIFO backpressure, reset mid-frame and a push during reset.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic       tx_o;
  logic       busy_o;
  logic [2:0] level_o;

  int checks = 0;
  int errors = 0;

  uart_transmitter dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .tx_o       (tx_o),
    .busy_o     (busy_o),
    .level_o    (level_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    string      name;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Waits (bounded) for a start bit, then checks all 10*8 cycles of the frame.
  // Returns positioned on the last stop-bit cycle.
  task automatic check_frame(input logic [9:0] fr, input string nm);
    int budget = 400;
    while (tx_o !== 1'b0 && budget > 0) begin
      tick();
      budget--;
    end
    chk({nm, " start"}, {31'd0, tx_o}, 32'd0);
    for (int k = 0; k < 80; k++) begin
      if (k != 0) tick();
      chk($sformatf("%s cyc%0d", nm, k), {31'd0, tx_o}, {31'd0, fr[k/8]});
    end
  endtask

  task automatic push1(input logic [7:0] d);
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    tick();
    tx_valid_i = 1'b0;
  endtask

  logic [9:0] fill_fr [6];

  initial begin
    vecs[0] = '{8'hA5, 10'b1_1010_0101_0, "byteA5"};
    vecs[1] = '{8'h3C, 10'b1_0011_1100_0, "byte3C"};
    vecs[2] = '{8'h00, 10'b1_0000_0000_0, "byte00"};
    vecs[3] = '{8'hFF, 10'b1_1111_1111_0, "byteFF"};
    vecs[4] = '{8'h01, 10'b1_0000_0001_0, "byte01"};
    vecs[5] = '{8'h80, 10'b1_1000_0000_0, "byte80"};
    fill_fr[0] = 10'b1_0001_0001_0;
    fill_fr[1] = 10'b1_0001_0010_0;
    fill_fr[2] = 10'b1_0001_0011_0;
    fill_fr[3] = 10'b1_0001_0100_0;
    fill_fr[4] = 10'b1_0001_0101_0;
    fill_fr[5] = 10'b1_0001_0110_0;

    reset      = 1'b1;
    tx_data_i  = 8'h00;
    tx_valid_i = 1'b0;
    tick();
    tick();
    chk("rst tx_o",  {31'd0, tx_o},       32'd1);
    chk("rst level", {29'd0, level_o},    32'd0);
    chk("rst ready", {31'd0, tx_ready_o}, 32'd1);
    chk("rst busy",  {31'd0, busy_o},     32'd0);
    reset = 1'b0;
    tick();

    // Single frames from the table, with latency and busy timing.
    for (int i = 0; i < 6; i++) begin
      push1(vecs[i].data);
      chk({vecs[i].name, " lvl1"},  {29'd0, level_o}, 32'd1);
      chk({vecs[i].name, " idle"},  {31'd0, tx_o},    32'd1);
      tick();
      chk({vecs[i].name, " lat"},   {31'd0, tx_o},    32'd0);
      chk({vecs[i].name, " lvl0"},  {29'd0, level_o}, 32'd0);
      check_frame(vecs[i].frame, vecs[i].name);
      chk({vecs[i].name, " busy79"}, {31'd0, busy_o}, 32'd1);
      tick();
      chk({vecs[i].name, " busy80"}, {31'd0, busy_o}, 32'd0);
      chk({vecs[i].name, " tx80"},   {31'd0, tx_o},   32'd1);
      tick();
    end

    // Back-to-back frames: second start bit exactly 80 cycles after the first.
    tx_data_i  = 8'h00;
    tx_valid_i = 1'b1;
    tick();
    tx_data_i  = 8'hFF;
    tick();
    tx_valid_i = 1'b0;
    check_frame(10'b1_0000_0000_0, "b2b0");
    tick();
    chk("b2b gap", {31'd0, tx_o}, 32'd0);
    check_frame(10'b1_1111_1111_0, "b2b1");
    tick();
    chk("b2b busy", {31'd0, busy_o}, 32'd0);
    tick();

    // Fill / backpressure with full+pop in the same cycle.
    fork
      begin : pusher
        int n;
        int budget;
        logic acc;
        n = 0;
        budget = 50;
        tx_data_i  = 8'h11;
        tx_valid_i = 1'b1;
        while (n < 5 && budget > 0) begin
          acc = tx_ready_o;
          tick();
          budget--;
          if (acc) begin
            n++;
            tx_data_i = 8'h11 + 8'(n);
          end
        end
        chk("fill accepts", n, 32'd5);
        chk("fill level4", {29'd0, level_o},    32'd4);
        chk("fill ready0", {31'd0, tx_ready_o}, 32'd0);
        budget = 200;
        while (level_o == 3'd4 && budget > 0) begin
          tick();
          budget--;
        end
        chk("full pop lvl3",  {29'd0, level_o},    32'd3);
        chk("full pop ready", {31'd0, tx_ready_o}, 32'd1);
        tick();
        chk("refill lvl4", {29'd0, level_o}, 32'd4);
        tx_valid_i = 1'b0;
      end
      begin : monitor
        for (int f = 0; f < 6; f++)
          check_frame(fill_fr[f], $sformatf("fill%0d", f));
        tick();
        chk("fill busy", {31'd0, busy_o}, 32'd0);
      end
    join
    tick();

    // Reset during data bit 3 of 0x3C with two bytes queued.
    begin : mid_reset
      int lows;
      tx_data_i  = 8'h3C;
      tx_valid_i = 1'b1;
      tick();
      tx_data_i  = 8'h55;
      tick();
      tx_data_i  = 8'hAA;
      tick();
      tx_valid_i = 1'b0;
      for (int k = 1; k < 35; k++) tick();
      chk("mid bit3",  {31'd0, tx_o},    32'd1);
      chk("mid lvl2",  {29'd0, level_o}, 32'd2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mrst tx_o",  {31'd0, tx_o},       32'd1);
      chk("mrst level", {29'd0, level_o},    32'd0);
      chk("mrst busy",  {31'd0, busy_o},     32'd0);
      chk("mrst ready", {31'd0, tx_ready_o}, 32'd1);
      lows = 0;
      for (int k = 0; k < 100; k++) begin
        tick();
        if (tx_o !== 1'b1 || busy_o !== 1'b0) lows++;
      end
      chk("mrst quiet", lows, 32'd0);
    end

    // Push presented during a reset cycle is dropped.
    begin : rst_push
      int bad;
      reset      = 1'b1;
      tx_data_i  = 8'h77;
      tx_valid_i = 1'b1;
      tick();
      reset      = 1'b0;
      tx_valid_i = 1'b0;
      chk("rpush level", {29'd0, level_o}, 32'd0);
      bad = 0;
      for (int k = 0; k < 20; k++) begin
        tick();
        if (tx_o !== 1'b1 || level_o !== 3'd0) bad++;
      end
      chk("rpush quiet", bad, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
